batch_spi_sender: RTL and testbench

BATCH_SPI_SENDER -- requirements
Module: batch_spi_sender

---
 rtl/batch_spi_pkg.sv | 18 +
 rtl/batch_spi_sender_clk_div.sv | 42 ++++
 rtl/batch_spi_sender.sv | 191 +++++++++++++++++++
 tb/tb_batch_spi_sender.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/batch_spi_pkg.sv
`default_nettype none
// batch_spi_pkg: shared FSM state type and counter-width helper for batch_spi_sender.
package batch_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Width of a counter that runs 0..n-1 (never narrower than one bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/batch_spi_sender_clk_div.sv
`default_nettype none
// spi_clk_div: CLK_DIV-cycle phase counter; rise_o ends a low phase, fall_o ends a high phase.
module spi_clk_div
  import batch_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          tick;

  assign tick   = en_i && (cnt_q == CNT_LAST);
  assign rise_o = tick & ~phase_q;
  assign fall_o = tick & phase_q;

  // Phase restarts low whenever disabled, so every frame begins with a low phase.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (tick) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/batch_spi_sender.sv
`default_nettype none
// batch_spi_sender: sends BATCH_SIZE-byte batches as mode-0 SPI frames, byte 0 first, MSB first.
// Define BATCH_SPI_PENDING_EN for a one-deep pending batch buffer.
module batch_spi_sender
  import batch_spi_pkg::*;
#(
  parameter int BATCH_SIZE = 8,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 4
) (
  input  logic                    I_rgb_clk,
  input  logic                    I_rst_n,
  input  logic                    I_batch_ready,
  input  logic [8*BATCH_SIZE-1:0] I_batch_color,
  input  logic                    I_overflow_clr,
  output logic                    O_spi_sclk,
  output logic                    O_spi_mosi,
  output logic                    O_spi_cs_n,
  output logic                    O_busy,
  output logic                    O_overflow
);
  localparam int NBITS = 8 * BATCH_SIZE;
  localparam int BW    = cnt_w(NBITS + 1);
  localparam int GW    = cnt_w(CS_GAP);
  localparam logic [BW-1:0] BITS_DONE = BW'(NBITS);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] sr_q, sr_d, color_rev, load_val;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, ovf_q, ovf_d;
  logic             load, load_new, ovf_evt, div_en, rise, fall;

`ifdef BATCH_SPI_PENDING_EN
  logic [NBITS-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
`endif

  // Byte 0 is placed at the top so the shifter always sends from the MSB.
  for (genvar k = 0; k < BATCH_SIZE; k++) begin : g_rev
    assign color_rev[NBITS-1-8*k -: 8] = I_batch_color[8*k +: 8];
  end

  assign div_en = (state_q == SETUP) || (state_q == SHIFT);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_i   (I_rgb_clk),
    .rst_n_i (I_rst_n),
    .en_i    (div_en),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    load     = 1'b0;
    load_new = 1'b0;
    load_val = color_rev;
    ovf_evt  = 1'b0;
`ifdef BATCH_SPI_PENDING_EN
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
`endif
    case (state_q)
      IDLE: begin
        if (I_batch_ready) begin
          load     = 1'b1;
          load_new = 1'b1;
        end
      end
      SETUP: begin
        if (rise) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (fall) begin
          sclk_d = 1'b0;
          sr_d   = sr_q << 1;
          mosi_d = sr_q[NBITS-2];
          bit_d  = bit_q + BW'(1);
        end else if (rise) begin
          // bit_q counts completed high phases; the frame ends after the last low phase
          if (bit_q == BITS_DONE) begin
            state_d = GAP;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            gap_d   = '0;
          end else begin
            sclk_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
`ifdef BATCH_SPI_PENDING_EN
          if (pend_v_q) begin
            load     = 1'b1;
            load_val = pend_q;
            pend_v_d = 1'b0;
          end else if (I_batch_ready) begin
            load     = 1'b1;
            load_new = 1'b1;
          end else begin
            state_d  = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = SETUP;
      sr_d    = load_val;
      mosi_d  = load_val[NBITS-1];
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      bit_d   = '0;
    end

    if (I_batch_ready && !load_new && (state_q != IDLE)) begin
`ifdef BATCH_SPI_PENDING_EN
      if (pend_v_q) begin
        ovf_evt = 1'b1;
      end else begin
        pend_d   = color_rev;
        pend_v_d = 1'b1;
      end
`else
      ovf_evt = 1'b1;
`endif
    end

    ovf_d = ovf_evt | (ovf_q & ~I_overflow_clr);
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef BATCH_SPI_PENDING_EN
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end
`endif

  assign O_spi_sclk = sclk_q;
  assign O_spi_mosi = mosi_q;
  assign O_spi_cs_n = cs_n_q;
  assign O_busy     = (state_q != IDLE);
  assign O_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_batch_spi_sender.sv
`default_nettype none
// tb_batch_spi_sender: directed checks of batch_spi_sender with default parameters.
module tb_batch_spi_sender;
  localparam int NB = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ready = 1'b0;
  logic [NB-1:0] color = '0;
  logic          ovf_clr = 1'b0;
  logic          sclk, mosi, cs_n, busy, ovf;

  batch_spi_sender dut (
    .I_rgb_clk      (clk),
    .I_rst_n        (rst_n),
    .I_batch_ready  (ready),
    .I_batch_color  (color),
    .I_overflow_clr (ovf_clr),
    .O_spi_sclk     (sclk),
    .O_spi_mosi     (mosi),
    .O_spi_cs_n     (cs_n),
    .O_busy         (busy),
    .O_overflow     (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Frame monitor: records each CS-low frame (length, bits sampled on SCLK rises)
  logic [NB-1:0] fr_data[$];
  int            fr_len[$];
  logic [NB-1:0] cur = '0;
  int            cur_len = 0, bit_i = 0, gap_cnt = 0, last_gap = 0, tail_cnt = 0;
  logic          prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      if (prev_cs) begin
        last_gap = gap_cnt;
        cur_len  = 0;
        bit_i    = 0;
        cur      = '0;
      end
      cur_len++;
      if (sclk && !prev_sclk && bit_i < NB) begin
        cur[8*(bit_i/8) + 7 - (bit_i%8)] = mosi;
        bit_i++;
      end
    end else begin
      if (!prev_cs) begin
        fr_data.push_back(cur);
        fr_len.push_back(cur_len);
        gap_cnt  = 0;
        tail_cnt = 0;
      end
      gap_cnt++;
      if (busy) tail_cnt++;
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [NB-1:0] d);
    color = d;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    color = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, NB'(busy), NB'(0));
  endtask

  localparam logic [NB-1:0] BA = 64'h07060504030201A5;
  localparam logic [NB-1:0] BB = 64'h1122334455667788;
  localparam logic [NB-1:0] BC = 64'hDEADBEEFCAFEF00D;
  localparam logic [NB-1:0] BD = 64'h5555AAAA3333CCCC;
  localparam logic [NB-1:0] BE = 64'h0F1E2D3C4B5A6978;

  int base;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs_n", NB'(cs_n), NB'(1));
    chk("rst_sclk", NB'(sclk), NB'(0));
    chk("rst_mosi", NB'(mosi), NB'(0));
    chk("rst_busy", NB'(busy), NB'(0));
    chk("rst_ovf",  NB'(ovf),  NB'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single batch: 0xA5 first, MSB first
    base = fr_len.size();
    pulse(BA);
    chk("start_cs_n", NB'(cs_n), NB'(0));
    chk("start_mosi", NB'(mosi), NB'(1));
    chk("start_sclk", NB'(sclk), NB'(0));
    chk("start_busy", NB'(busy), NB'(1));
    wait_idle("single_timeout", 1000);
    chk("single_count", NB'(fr_len.size() - base), NB'(1));
    chk("single_len",   NB'(fr_len[base]), NB'(258));
    chk("single_byte0", NB'(fr_data[base][7:0]), NB'(8'hA5));
    chk("single_data",  fr_data[base], BA);
    chk("busy_tail",    NB'(tail_cnt), NB'(4));
    chk("single_ovf",   NB'(ovf), NB'(0));
    repeat (5) @(negedge clk);

    // Three strobes 10 cycles apart; the third coincides with overflow clear
    base = fr_len.size();
    pulse(BA);
    repeat (9) @(negedge clk);
    pulse(BB);
`ifdef BATCH_SPI_PENDING_EN
    chk("second_ovf", NB'(ovf), NB'(0));
`else
    chk("second_ovf", NB'(ovf), NB'(1));
`endif
    repeat (9) @(negedge clk);
    color   = BC;
    ready   = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    ready   = 1'b0;
    ovf_clr = 1'b0;
    chk("set_wins_ovf", NB'(ovf), NB'(1));
    wait_idle("multi_timeout", 3000);
    repeat (20) @(negedge clk);
`ifdef BATCH_SPI_PENDING_EN
    chk("multi_count", NB'(fr_len.size() - base), NB'(2));
    chk("multi_data1", fr_data[base], BA);
    chk("multi_data2", fr_data[base+1], BB);
    chk("multi_len2",  NB'(fr_len[base+1]), NB'(258));
    chk("multi_gap",   NB'(last_gap), NB'(4));
`else
    chk("multi_count", NB'(fr_len.size() - base), NB'(1));
    chk("multi_data1", fr_data[base], BA);
`endif
    chk("multi_ovf_held", NB'(ovf), NB'(1));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", NB'(ovf), NB'(0));
    repeat (5) @(negedge clk);

    // Reset at bit 20 of a frame aborts it immediately
    pulse(BD);
    repeat (82) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", NB'(cs_n), NB'(1));
    chk("abort_sclk", NB'(sclk), NB'(0));
    chk("abort_mosi", NB'(mosi), NB'(0));
    chk("abort_busy", NB'(busy), NB'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_rst_busy", NB'(busy), NB'(0));
    base = fr_len.size();
    pulse(BE);
    wait_idle("post_rst_timeout", 1000);
    chk("post_rst_count", NB'(fr_len.size() - base), NB'(1));
    chk("post_rst_len",   NB'(fr_len[base]), NB'(258));
    chk("post_rst_data",  fr_data[base], BE);
    chk("post_rst_ovf",   NB'(ovf), NB'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
